alu_mul_iter: RTL and testbench
===============================

ALU_MUL_ITER -- requirements
Module: alu_mul_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; SHALL be legal for any WIDTH >= 4.
REQ-002 Port: clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-low: the block SHALL reset on a rising clk edge while reset=0.
REQ-004 Port: start  input  1  operation request, sampled on the rising clk edge.
REQ-005 Port: a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 Port: alu_control  input  3  op select, captured when start is accepted: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL, 110 SMULL, 111 reserved.
REQ-008 Port: busy  output  1  high while a multiply is iterating.
REQ-009 Port: done  output  1  one-cycle completion pulse, one per accepted op.
REQ-010 Port: result_lo  output  WIDTH  low result word.
REQ-011 Port: result_hi  output  WIDTH  high result word; 0 for non-long ops.
REQ-012 Port: alu_flags  output  4  {N,Z,C,V} of the last completed op.

Function
REQ-013 FSM states SHALL be IDLE, MULT and DONE; start SHALL be accepted only in IDLE or DONE.
REQ-014 Start SHALL be ignored while the FSM is in MULT, with no effect on state, operands or outputs.
REQ-015 Ops ADD, SUB, AND, ORR and reserved SHALL go IDLE/DONE->DONE, with done high in the cycle after the accepting edge (latency 1).
REQ-016 Ops MUL, UMULL and SMULL SHALL go to MULT for exactly WIDTH clock edges of radix-2 shift-add, then to DONE (latency WIDTH edges from accept).
REQ-017 DONE with no start SHALL return to IDLE; DONE with start SHALL accept the new op, so back-to-back ALU ops give done high on consecutive cycles.
REQ-018 busy SHALL be 1 exactly while in MULT; done SHALL be 1 exactly while in DONE.
REQ-019 ADD/SUB SHALL compute a + (b or ~b) + alu_control[0] in WIDTH+1 bits, with result_lo equal to bits [WIDTH-1:0].
REQ-020 ADD/SUB flags: N = result_lo[WIDTH-1]; Z = (result_lo == 0); C = carry-out bit WIDTH; V = ~(a^b^alu_control[0])[MSB] & (a^sum)[MSB].
REQ-021 AND/ORR SHALL set N and Z from result_lo and force C = V = 0.
REQ-022 MUL SHALL output the low WIDTH bits of the product on result_lo, with result_hi = 0, N = lo[MSB], Z = (lo == 0), C = V = 0.
REQ-023 UMULL SHALL output the unsigned 2*WIDTH-bit product on {result_hi, result_lo}; SMULL SHALL output the two's-complement signed product.
REQ-024 Long-op flags: N = result_hi[WIDTH-1]; Z = ({hi,lo} == 0); C = V = 0.
REQ-025 Reserved op 111 SHALL give result_lo = result_hi = 0 and flags 0000.
REQ-026 result_lo, result_hi and alu_flags SHALL update only on the edge entering DONE and SHALL hold until the next completion.
REQ-027 Operand, op or start changes after acceptance SHALL NOT affect the op in flight.

Reset
REQ-028 On reset: state = IDLE, busy = 0, done = 0, result_lo = result_hi = 0, alu_flags = 0000, internal accumulator cleared.
REQ-029 Reset asserted mid-MULT SHALL abort the op, with no done pulse and no result or flag update for that op.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification (WIDTH=32)
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> done 1 cycle later, lo = 0x80000000, hi = 0, flags = 1001.
REQ-032 SUB 5 - 5, back-to-back with ORR 0xF0 | 0x0F -> done on two consecutive cycles: first lo = 0 with flags 0110, then lo = 0xFF with flags 0000.
REQ-033 UMULL 0xFFFFFFFF * 0xFFFFFFFF -> busy for 32 cycles, then hi = 0xFFFFFFFE, lo = 0x00000001, flags 1000; a start pulse mid-op is ignored.
REQ-034 SMULL 0xFFFFFFFE * 0x00000003 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, flags 1000; MUL 0x00010000 * 0x00010000 -> lo = 0, hi = 0, flags 0100.
REQ-035 reset = 0 at the 10th MULT cycle -> next cycle busy = 0, done = 0 and all outputs 0; no done appears afterwards without a new start.

Source files
------------

// File: rtl/alu_mul_iter.sv
// Four-function ALU plus an iterative radix-2 shift-add multiplier.
// ALU ops complete one cycle after acceptance; multiplies take WIDTH cycles.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       alu_flags
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL, OP_UMULL, OP_SMULL, OP_RSVD
   } op_t;

   state_t             state;
   op_t                op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      cnt_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_lo;
   logic [3:0]         alu_fl;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     part;
   logic [2*WIDTH-1:0] acc_nxt, prod;
   logic [WIDTH-1:0]   mul_lo, mul_hi;
   logic [3:0]         mul_fl;
   logic               is_mul;

   // Single-cycle ALU path, evaluated on the live inputs at the accepting edge.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sum    = {1'b0, a} + {1'b0, (alu_control[0] ? ~b : b)} + {{WIDTH{1'b0}}, alu_control[0]};
      alu_lo = '0;
      alu_fl = '0;
      case (alu_control)
         OP_ADD, OP_SUB: begin
            alu_lo    = sum[WIDTH-1:0];
            alu_fl[1] = sum[WIDTH];
            alu_fl[0] = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ alu_control[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
         end
         OP_AND: alu_lo = a & b;
         OP_ORR: alu_lo = a | b;
         default: alu_lo = '0;
      endcase
      if (alu_control != OP_RSVD) begin
         alu_fl[3] = alu_lo[WIDTH-1];
         alu_fl[2] = (alu_lo == '0);
      end
   end

   // Signed multiply runs on magnitudes; the sign is reapplied to the full product.
   always_comb begin
      is_mul = (alu_control == OP_MUL) || (alu_control == OP_UMULL) || (alu_control == OP_SMULL);
      a_neg  = (alu_control == OP_SMULL) && a[WIDTH-1];
      b_neg  = (alu_control == OP_SMULL) && b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
   end

   always_comb begin
      part    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_nxt = {part, acc_q[WIDTH-1:1]};
      prod    = neg_q ? -acc_nxt : acc_nxt;
      mul_lo  = prod[WIDTH-1:0];
      mul_hi  = '0;
      mul_fl  = '0;
      if (op_q == OP_MUL) begin
         mul_fl[3] = mul_lo[WIDTH-1];
         mul_fl[2] = (mul_lo == '0);
      end else begin
         mul_hi    = prod[2*WIDTH-1:WIDTH];
         mul_fl[3] = prod[2*WIDTH-1];
         mul_fl[2] = (prod == '0);
      end
   end

   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= OP_ADD;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         alu_flags <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_q <= op_t'(alu_control);
                  if (is_mul) begin
                     state   <= MULT;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                     mcand_q <= a_mag;
                     acc_q   <= {{WIDTH{1'b0}}, b_mag};
                     neg_q   <= a_neg ^ b_neg;
                     cnt_q   <= '0;
                  end else begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     result_lo <= alu_lo;
                     result_hi <= '0;
                     alu_flags <= alu_fl;
                  end
               end else begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            MULT: begin
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result_lo <= mul_lo;
                  result_hi <= mul_hi;
                  alu_flags <= mul_fl;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_iter.sv
// Self-checking bench for alu_mul_iter: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_mul_iter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a, b;
   logic [2:0]    alu_control;
   logic          busy, done;
   logic [W-1:0]  result_lo, result_hi;
   logic [3:0]    alu_flags;

   int checks = 0;
   int errors = 0;

   alu_mul_iter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .alu_control(alu_control), .busy(busy), .done(done),
      .result_lo(result_lo), .result_hi(result_hi), .alu_flags(alu_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no summary, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: results straight from integer arithmetic.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] ia, ib,
                                 output logic [W-1:0] lo, hi, output logic [3:0] fl);
      logic [63:0] ua, ub, p;
      longint      sa, sb, ss;
      logic        c, v;
      ua = {32'h0, ia};
      ub = {32'h0, ib};
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      lo = '0; hi = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin p = ua + ub; lo = p[31:0]; c = p[32]; ss = sa + sb;
                     v = (ss != longint'($signed(lo))); end
         3'd1: begin lo = ia - ib; c = (ia >= ib); ss = sa - sb;
                     v = (ss != longint'($signed(lo))); end
         3'd2: lo = ia & ib;
         3'd3: lo = ia | ib;
         3'd4: begin p = ua * ub; lo = p[31:0]; end
         3'd5: begin p = ua * ub; lo = p[31:0]; hi = p[63:32]; end
         3'd6: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
         default: ;
      endcase
      if (op == 3'd7)                      fl = 4'b0000;
      else if (op == 3'd5 || op == 3'd6)   fl = {hi[31], ({hi, lo} == 64'h0), 2'b00};
      else                                 fl = {lo[31], (lo == 32'h0), c, v};
   endfunction

   // Issue one op, wait (bounded) for done, compare against the model.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] ia, ib, input bit mid_start);
      logic [W-1:0] elo, ehi;
      logic [3:0]   efl;
      int           n, busy_cnt, exp_lat;
      model(op, ia, ib, elo, ehi, efl);
      exp_lat = (op >= 3'd4 && op <= 3'd6) ? W : 0;
      @(negedge clk);
      start = 1'b1; alu_control = op; a = ia; b = ib;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; alu_control = 3'($urandom_range(0, 7));
      n = 0; busy_cnt = 0;
      while (!done && n < W + 8) begin
         if (busy) busy_cnt++;
         if (mid_start && n == 5) begin
            start = 1'b1; a = $urandom; b = $urandom; alu_control = 3'd0;
         end else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check($sformatf("latency op%0d", op), 64'(n), 64'(exp_lat));
      check($sformatf("busy_cycles op%0d", op), 64'(busy_cnt), 64'(exp_lat));
      check($sformatf("lo op%0d a=%h b=%h", op, ia, ib), 64'(result_lo), 64'(elo));
      check($sformatf("hi op%0d a=%h b=%h", op, ia, ib), 64'(result_hi), 64'(ehi));
      check($sformatf("flags op%0d a=%h b=%h", op, ia, ib), 64'(alu_flags), 64'(efl));
      @(negedge clk);
      check($sformatf("done_pulse op%0d", op), 64'(done), 64'(0));
      check($sformatf("lo_hold op%0d", op), 64'(result_lo), 64'(elo));
   endtask

   initial begin
      int dcount;
      reset = 1'b0; start = 1'b0; a = '0; b = '0; alu_control = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_lo", 64'(result_lo), 64'(0));
      check("rst_hi", 64'(result_hi), 64'(0));
      check("rst_flags", 64'(alu_flags), 64'(0));
      reset = 1'b1;

      // Signed overflow on ADD
      run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      check("add_ovf_lo", 64'(result_lo), 64'h8000_0000);
      check("add_ovf_flags", 64'(alu_flags), 64'(4'b1001));

      // Back-to-back SUB then ORR
      @(negedge clk);
      start = 1'b1; alu_control = 3'd1; a = 32'd5; b = 32'd5;
      @(negedge clk);
      check("b2b_sub_done", 64'(done), 64'(1));
      check("b2b_sub_lo", 64'(result_lo), 64'(0));
      check("b2b_sub_flags", 64'(alu_flags), 64'(4'b0110));
      alu_control = 3'd3; a = 32'hF0; b = 32'h0F;
      @(negedge clk);
      start = 1'b0;
      check("b2b_orr_done", 64'(done), 64'(1));
      check("b2b_orr_lo", 64'(result_lo), 64'hFF);
      check("b2b_orr_flags", 64'(alu_flags), 64'(4'b0000));
      @(negedge clk);
      check("b2b_idle_done", 64'(done), 64'(0));

      // Long multiplies and the ignored mid-op start
      run_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("umull_hi", 64'(result_hi), 64'hFFFF_FFFE);
      check("umull_lo", 64'(result_lo), 64'h0000_0001);
      check("umull_flags", 64'(alu_flags), 64'(4'b1000));
      run_op(3'd6, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
      check("smull_hi", 64'(result_hi), 64'hFFFF_FFFF);
      check("smull_lo", 64'(result_lo), 64'hFFFF_FFFA);
      check("smull_flags", 64'(alu_flags), 64'(4'b1000));
      run_op(3'd4, 32'h0001_0000, 32'h0001_0000, 1'b0);
      check("mul_zero_flags", 64'(alu_flags), 64'(4'b0100));
      run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

      // Reset in the 10th MULT cycle aborts the op
      @(negedge clk);
      start = 1'b1; alu_control = 3'd5; a = 32'hDEAD_BEEF; b = 32'h0000_0007;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'(1));
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_lo", 64'(result_lo), 64'(0));
      check("abort_hi", 64'(result_hi), 64'(0));
      check("abort_flags", 64'(alu_flags), 64'(0));
      reset = 1'b1;
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", 64'(dcount), 64'(0));

      // Reset wins over a simultaneous start
      start = 1'b1; alu_control = 3'd0; a = 32'd1; b = 32'd2; reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      check("rst_prio_done", 64'(done), 64'(0));
      check("rst_prio_lo", 64'(result_lo), 64'(0));
      @(negedge clk);
      check("rst_prio_after", 64'(done), 64'(0));

      // Random ops against the model
      for (int i = 0; i < 50; i++) begin
         logic [2:0] op;
         logic [W-1:0] ra, rb;
         op = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : $urandom;
         run_op(op, ra, rb, (i % 7 == 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
